// File: rtl/lock_pkg.sv
// Shared definitions for the A/B/I lock FSM and its stimulus driver:
// state encodings, command codes and the F value each command should leave behind.
package lock_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_DRIVE  = 3'd1;
    localparam logic [2:0] ST_GAP    = 3'd2;
    localparam logic [2:0] ST_SAMPLE = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    localparam logic [1:0] CMD_ARM     = 2'd0;
    localparam logic [1:0] CMD_DISARM  = 2'd1;
    localparam logic [1:0] CMD_INSTANT = 2'd2;
    localparam logic [1:0] CMD_ILLEGAL = 2'd3;

    // One bit per command code; INSTANT reads 0 because I is already released at sample time.
    localparam logic [3:0] EXPECTED_F_TABLE = 4'b0001;

    function automatic logic expected_f(input logic [1:0] code);
        return EXPECTED_F_TABLE[code];
    endfunction

endpackage

// File: rtl/fsm_stim_driver.sv
// Drives one A/B/I command into the lock FSM, waits, samples F and reports
// whether the lock reached the expected state.
module fsm_stim_driver
    import lock_pkg::*;
#(
    parameter int HOLD_CYCLES  = 2,
    parameter int SAMPLE_DELAY = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] cmd,
    input  logic       f_in,
    output logic       a_out,
    output logic       b_out,
    output logic       i_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic       err,
    output logic       f_sampled
);

    localparam logic [7:0] HOLD_LAST   = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] SAMPLE_LAST = 8'(SAMPLE_DELAY - 1);

    logic [2:0] state;
    logic [2:0] state_next;
    logic [7:0] cnt;
    logic [1:0] cmd_q;
    logic [1:0] drive_cmd;

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (start) state_next = (cmd == CMD_ILLEGAL) ? ST_DONE : ST_DRIVE;
            ST_DRIVE:  if (cnt == HOLD_LAST) state_next = ST_GAP;
            ST_GAP:    if (cnt == SAMPLE_LAST) state_next = ST_SAMPLE;
            ST_SAMPLE: state_next = ST_DONE;
            ST_DONE:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // On the entry edge the latched copy is not yet valid, so the live cmd selects the line.
    assign drive_cmd = (state == ST_IDLE) ? cmd : cmd_q;

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= 8'd0;
            cmd_q     <= CMD_ARM;
            a_out     <= 1'b0;
            b_out     <= 1'b0;
            i_out     <= 1'b0;
            pass      <= 1'b0;
            err       <= 1'b0;
            f_sampled <= 1'b0;
        end else begin
            state <= state_next;

            if (state_next != state) begin
                cnt <= 8'd0;
            end else if (state == ST_DRIVE || state == ST_GAP) begin
                cnt <= cnt + 8'd1;
            end

            a_out <= (state_next == ST_DRIVE) && (drive_cmd == CMD_ARM);
            b_out <= (state_next == ST_DRIVE) && (drive_cmd == CMD_DISARM);
            i_out <= (state_next == ST_DRIVE) && (drive_cmd == CMD_INSTANT);

            if (state == ST_IDLE && start) begin
                pass <= 1'b0;
                if (cmd == CMD_ILLEGAL) begin
                    err <= 1'b1;
                end else begin
                    err   <= 1'b0;
                    cmd_q <= cmd;
                end
            end

            if (state == ST_SAMPLE) begin
                f_sampled <= f_in;
                pass      <= (f_in == expected_f(cmd_q));
            end
        end
    end

endmodule

// File: tb/tb_fsm_stim_driver.sv
// Directed bench for fsm_stim_driver, with a small behavioural A/B/I lock
// supplying F: A sets it, B clears it, I pulses it for one cycle.
module tb_fsm_stim_driver;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [1:0] cmd;
    logic       f_in;
    logic       a_out;
    logic       b_out;
    logic       i_out;
    logic       busy;
    logic       done;
    logic       pass;
    logic       err;
    logic       f_sampled;

    logic armed;
    logic i_seen;
    int   compared;
    int   mismatched;
    int   done_cnt;

    fsm_stim_driver #(.HOLD_CYCLES(2), .SAMPLE_DELAY(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .cmd       (cmd),
        .f_in      (f_in),
        .a_out     (a_out),
        .b_out     (b_out),
        .i_out     (i_out),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err       (err),
        .f_sampled (f_sampled)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed  <= 1'b0;
            i_seen <= 1'b0;
        end else begin
            if (a_out) armed <= 1'b1;
            else if (b_out) armed <= 1'b0;
            i_seen <= i_out;
        end
    end

    assign f_in = armed | (i_out & ~i_seen);

    always @(negedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
            $error("[TB] check %s differs", tag);
        end
    endtask

    // Issues one request from a negedge and runs until done, counting line activity.
    task automatic applyStimulus(input logic [1:0] c, output int lat, output int a_hi,
                                 output int b_hi, output int i_hi, output int f_hi);
        start = 1'b1;
        cmd   = c;
        lat   = 1;
        a_hi  = 0;
        b_hi  = 0;
        i_hi  = 0;
        f_hi  = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            lat++;
            a_hi += int'(a_out);
            b_hi += int'(b_out);
            i_hi += int'(i_out);
            f_hi += int'(f_in);
        end while (!done && lat < 40);
        checkOutput("done_seen", int'(done), 1);
    endtask

    initial begin
        int lat, a_hi, b_hi, i_hi, f_hi, base;
        compared   = 0;
        mismatched = 0;
        done_cnt   = 0;
        rst_n      = 1'b0;
        start      = 1'b0;
        cmd        = 2'd0;

        repeat (2) @(negedge clk);
        checkOutput("rst_a", int'(a_out), 0);
        checkOutput("rst_b", int'(b_out), 0);
        checkOutput("rst_i", int'(i_out), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_done", int'(done), 0);
        checkOutput("rst_pass", int'(pass), 0);
        checkOutput("rst_err", int'(err), 0);
        checkOutput("rst_fs", int'(f_sampled), 0);
        rst_n = 1'b1;
        @(negedge clk);

        applyStimulus(2'd0, lat, a_hi, b_hi, i_hi, f_hi);
        checkOutput("arm_lat", lat, 6);
        checkOutput("arm_a_hi", a_hi, 2);
        checkOutput("arm_other_hi", b_hi + i_hi, 0);
        checkOutput("arm_busy", int'(busy), 1);
        checkOutput("arm_pass", int'(pass), 1);
        checkOutput("arm_err", int'(err), 0);
        checkOutput("arm_fs", int'(f_sampled), 1);
        @(negedge clk);
        checkOutput("arm_done_single", int'(done), 0);
        checkOutput("arm_idle_busy", int'(busy), 0);
        checkOutput("arm_pass_held", int'(pass), 1);

        applyStimulus(2'd1, lat, a_hi, b_hi, i_hi, f_hi);
        checkOutput("disarm_lat", lat, 6);
        checkOutput("disarm_b_hi", b_hi, 2);
        checkOutput("disarm_other_hi", a_hi + i_hi, 0);
        checkOutput("disarm_pass", int'(pass), 1);
        checkOutput("disarm_fs", int'(f_sampled), 0);
        @(negedge clk);

        applyStimulus(2'd1, lat, a_hi, b_hi, i_hi, f_hi);
        checkOutput("disarm_s0_pass", int'(pass), 1);
        checkOutput("disarm_s0_fs", int'(f_sampled), 0);
        @(negedge clk);

        applyStimulus(2'd2, lat, a_hi, b_hi, i_hi, f_hi);
        checkOutput("inst_lat", lat, 6);
        checkOutput("inst_i_hi", i_hi, 2);
        checkOutput("inst_other_hi", a_hi + b_hi, 0);
        checkOutput("inst_f_pulse", f_hi, 1);
        checkOutput("inst_pass", int'(pass), 1);
        checkOutput("inst_fs", int'(f_sampled), 0);
        @(negedge clk);

        applyStimulus(2'd3, lat, a_hi, b_hi, i_hi, f_hi);
        checkOutput("ill_lat", lat, 2);
        checkOutput("ill_lines", a_hi + b_hi + i_hi, 0);
        checkOutput("ill_err", int'(err), 1);
        checkOutput("ill_pass", int'(pass), 0);
        @(negedge clk);
        checkOutput("ill_err_held", int'(err), 1);

        // Extra start pulses in DRIVE (with cmd changed) and in DONE must be dropped.
        #1 base = done_cnt;
        a_hi = 0;
        b_hi = 0;
        start = 1'b1;
        cmd   = 2'd0;
        for (int k = 2; k <= 9; k++) begin
            @(negedge clk);
            a_hi += int'(a_out);
            b_hi += int'(b_out);
            if (k == 6) begin
                checkOutput("dbl_done_c6", int'(done), 1);
                checkOutput("dbl_pass", int'(pass), 1);
                checkOutput("dbl_err_cleared", int'(err), 0);
            end
            if (k == 7) checkOutput("dbl_idle_after_done", int'(busy), 0);
            start = (k == 3 || k == 6);
            if (k == 3) cmd = 2'd1;
        end
        start = 1'b0;
        #1;
        checkOutput("dbl_done_count", done_cnt - base, 1);
        checkOutput("dbl_a_hi", a_hi, 2);
        checkOutput("dbl_b_hi", b_hi, 0);
        @(negedge clk);

        // Reset in the middle of DRIVE.
        base  = done_cnt;
        start = 1'b1;
        cmd   = 2'd0;
        @(negedge clk);
        start = 1'b0;
        checkOutput("mid_a_before", int'(a_out), 1);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_a_drop", int'(a_out), 0);
        checkOutput("mid_busy", int'(busy), 0);
        checkOutput("mid_done", int'(done), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(2'd0, lat, a_hi, b_hi, i_hi, f_hi);
        checkOutput("post_rst_lat", lat, 6);
        checkOutput("post_rst_a_hi", a_hi, 2);
        checkOutput("post_rst_pass", int'(pass), 1);
        #1;
        checkOutput("post_rst_done_count", done_cnt - base, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
